// File: rtl/monolith_axis_ip_slave_sif.sv
// AXI4-Stream slave that packs incoming beats into fixed-size chunks and
// queues them in a small ring of chunk slots for a parallel-read consumer.
module monolith_axis_ip_slave_sif #(
  parameter int FIFO_CHUNK_SIZE      = 16,
  parameter int FIFO_CHUNK_COUNT     = 2,
  parameter int C_S_AXIS_TDATA_WIDTH = 32
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESETN,
  input  logic                              S_AXIS_TVALID,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   fifo_out [0:FIFO_CHUNK_SIZE-1],
  output logic [$clog2(FIFO_CHUNK_SIZE):0]  chunk_words,
  output logic                              chunk_first,
  output logic                              chunk_last,
  output logic                              fifo_empty,
  output logic                              fifo_full,
  input  logic                              fifo_read_strobe
);

  localparam int WIDX = (FIFO_CHUNK_SIZE > 1) ? $clog2(FIFO_CHUNK_SIZE) : 1;
  localparam int PW   = $clog2(FIFO_CHUNK_COUNT);
  localparam int OW   = PW + 1;
  localparam int CW   = $clog2(FIFO_CHUNK_SIZE) + 1;

  typedef enum logic {IDLE, IN_PACKET} state_t;

  state_t            state;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [OW-1:0]     occupancy;
  logic [WIDX-1:0]   word_cnt;
  logic              open_first;

  logic [C_S_AXIS_TDATA_WIDTH-1:0] mem [FIFO_CHUNK_COUNT][FIFO_CHUNK_SIZE];
  logic [CW-1:0]     meta_words [FIFO_CHUNK_COUNT];
  logic              meta_first [FIFO_CHUNK_COUNT];
  logic              meta_last  [FIFO_CHUNK_COUNT];

  logic accept;
  logic chunk_end;
  logic pop;
  logic beat_first;

  // Byte strobes carry no information here; every byte is payload.
  logic unused_tstrb;
  assign unused_tstrb = ^S_AXIS_TSTRB;

  assign fifo_empty    = (occupancy == '0);
  assign fifo_full     = (occupancy == OW'(FIFO_CHUNK_COUNT));
  assign S_AXIS_TREADY = S_AXIS_ARESETN & ~fifo_full;

  assign accept     = S_AXIS_TVALID & S_AXIS_TREADY;
  assign chunk_end  = accept & (S_AXIS_TLAST | (word_cnt == WIDX'(FIFO_CHUNK_SIZE - 1)));
  assign pop        = fifo_read_strobe & ~fifo_empty;
  // A chunk opens a packet only if its very first beat arrived with no packet open.
  assign beat_first = (word_cnt == '0) ? (state == IDLE) : open_first;

  // NOTE: payload storage has no reset; stale words are hidden by the output
  // masking below, so only pointers and metadata need a defined reset value.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (accept) mem[wr_ptr][word_cnt] <= S_AXIS_TDATA;
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      word_cnt   <= '0;
      open_first <= 1'b0;
      for (int s = 0; s < FIFO_CHUNK_COUNT; s++) begin
        meta_words[s] <= '0;
        meta_first[s] <= 1'b0;
        meta_last[s]  <= 1'b0;
      end
    end else begin
      if (accept) begin
        word_cnt <= chunk_end ? '0 : word_cnt + WIDX'(1);
        if (word_cnt == '0) open_first <= (state == IDLE);
        case (state)
          IDLE:      if (!S_AXIS_TLAST) state <= IN_PACKET;
          IN_PACKET: if (S_AXIS_TLAST)  state <= IDLE;
          default:   state <= IDLE;
        endcase
      end
      if (chunk_end) begin
        meta_words[wr_ptr] <= CW'(word_cnt) + CW'(1);
        meta_first[wr_ptr] <= beat_first;
        meta_last[wr_ptr]  <= S_AXIS_TLAST;
        wr_ptr             <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      occupancy <= occupancy + OW'(chunk_end) - OW'(pop);
    end
  end

  // NOTE: every output gets a default first so this block can never infer a latch.
  always_comb begin
    chunk_words = '0;
    chunk_first = 1'b0;
    chunk_last  = 1'b0;
    for (int i = 0; i < FIFO_CHUNK_SIZE; i++) fifo_out[i] = '0;
    if (!fifo_empty) begin
      chunk_words = meta_words[rd_ptr];
      chunk_first = meta_first[rd_ptr];
      chunk_last  = meta_last[rd_ptr];
      for (int i = 0; i < FIFO_CHUNK_SIZE; i++) begin
        if (CW'(i) < meta_words[rd_ptr]) fifo_out[i] = mem[rd_ptr][i];
      end
    end
  end

endmodule

// File: tb/tb_monolith_axis_ip_slave_sif.sv
// Self-checking bench: randomized and directed streams against a chunk-queue
// reference model, compared on every falling edge.
module tb_monolith_axis_ip_slave_sif;

  localparam int SIZE  = 16;
  localparam int COUNT = 2;
  localparam int W     = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tvalid = 1'b0;
  logic [W-1:0]  tdata = '0;
  logic [W/8-1:0] tstrb = '1;
  logic          tlast = 1'b0;
  logic          tready;
  logic [W-1:0]  fifo_out [0:SIZE-1];
  logic [4:0]    chunk_words;
  logic          chunk_first;
  logic          chunk_last;
  logic          fifo_empty;
  logic          fifo_full;
  logic          strobe = 1'b0;

  int checks = 0;
  int errors = 0;

  monolith_axis_ip_slave_sif #(
    .FIFO_CHUNK_SIZE(SIZE), .FIFO_CHUNK_COUNT(COUNT), .C_S_AXIS_TDATA_WIDTH(W)
  ) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .S_AXIS_TVALID(tvalid),
    .S_AXIS_TDATA(tdata), .S_AXIS_TSTRB(tstrb), .S_AXIS_TLAST(tlast),
    .S_AXIS_TREADY(tready), .fifo_out(fifo_out), .chunk_words(chunk_words),
    .chunk_first(chunk_first), .chunk_last(chunk_last), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_read_strobe(strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of committed chunks plus the chunk being assembled.
  logic [SIZE*W-1:0] q_w [$];
  int                q_n [$];
  bit                q_f [$];
  bit                q_l [$];
  logic [SIZE*W-1:0] pw = '0;
  int                pn = 0;
  bit                pf = 0;
  bit                in_pkt = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q_w.delete(); q_n.delete(); q_f.delete(); q_l.delete();
        pw = '0; pn = 0; pf = 0; in_pkt = 0;
      end else begin
        int  sz;
        bit  acc, pp;
        sz  = q_w.size();
        acc = tvalid && (sz < COUNT);
        pp  = strobe && (sz > 0);
        if (pp) begin
          void'(q_w.pop_front()); void'(q_n.pop_front());
          void'(q_f.pop_front()); void'(q_l.pop_front());
        end
        if (acc) begin
          if (pn == 0) pf = !in_pkt;
          pw[pn*W +: W] = tdata;
          pn++;
          if (tlast || pn == SIZE) begin
            q_w.push_back(pw); q_n.push_back(pn);
            q_f.push_back(pf); q_l.push_back(tlast);
            pw = '0; pn = 0;
          end
          in_pkt = !tlast;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      begin
        int sz;
        sz = q_w.size();
        check("tready", tready, rst_n && (sz < COUNT));
        check("empty", fifo_empty, sz == 0);
        check("full", fifo_full, sz == COUNT);
        check("words", chunk_words, (sz > 0) ? q_n[0] : 0);
        check("first", chunk_first, (sz > 0) ? q_f[0] : 1'b0);
        check("last", chunk_last, (sz > 0) ? q_l[0] : 1'b0);
        for (int i = 0; i < SIZE; i++)
          check($sformatf("fifo_out[%0d]", i), fifo_out[i],
                (sz > 0) ? q_w[0][i*W +: W] : '0);
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic l);
    int   n;
    logic rdy;
    n = 0;
    tvalid = 1'b1; tdata = d; tlast = l;
    do begin
      @(negedge clk); rdy = tready;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 100);
    if (!rdy) check("send_timeout", 0, 1);
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic pop_once();
    strobe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    idle(3);
    check("rst_tready", tready, 0);
    check("rst_empty", fifo_empty, 1);
    rst_n = 1'b1;
    idle(2);

    // Full 16-word packet.
    for (int i = 0; i < 16; i++) send(W'(i), i == 15);
    check("p16_empty", fifo_empty, 0);
    check("p16_words", chunk_words, 16);
    check("p16_first", chunk_first, 1);
    check("p16_last", chunk_last, 1);
    for (int i = 0; i < 16; i++) check($sformatf("p16_out%0d", i), fifo_out[i], W'(i));
    pop_once();
    check("p16_popped", fifo_empty, 1);

    // Short packet: tail words must read zero.
    for (int i = 0; i < 5; i++) send(W'(32'hA1 + i), i == 4);
    check("p5_words", chunk_words, 5);
    check("p5_out0", fifo_out[0], 32'hA1);
    check("p5_out4", fifo_out[4], 32'hA5);
    check("p5_out5", fifo_out[5], 0);
    check("p5_out15", fifo_out[15], 0);
    check("p5_first", chunk_first, 1);
    check("p5_last", chunk_last, 1);
    pop_once();

    // 20-beat packet spans two chunks.
    for (int i = 0; i < 20; i++) send(W'(32'h200 + i), i == 19);
    check("p20a_words", chunk_words, 16);
    check("p20a_first", chunk_first, 1);
    check("p20a_last", chunk_last, 0);
    pop_once();
    check("p20b_words", chunk_words, 4);
    check("p20b_first", chunk_first, 0);
    check("p20b_last", chunk_last, 1);
    check("p20b_out3", fifo_out[3], 32'h213);
    pop_once();

    // Backpressure: 48 beats with one pop in the middle.
    for (int i = 0; i < 32; i++) send(W'(32'h100 + i), 1'b0);
    check("bp_full", fifo_full, 1);
    check("bp_tready", tready, 0);
    tvalid = 1'b1; tdata = 32'hDEAD;
    idle(3);
    tvalid = 1'b0;
    check("bp_still_full", fifo_full, 1);
    pop_once();
    check("bp_tready_back", tready, 1);
    for (int i = 32; i < 48; i++) send(W'(32'h100 + i), i == 47);
    check("bp_head1", fifo_out[0], 32'h110);
    check("bp_head1_first", chunk_first, 0);
    pop_once();
    check("bp_head2", fifo_out[0], 32'h120);
    check("bp_head2_last", chunk_last, 1);
    pop_once();

    // Single-beat packet, then commit and pop on the same edge.
    send(32'h55, 1'b1);
    check("p1_words", chunk_words, 1);
    check("p1_first", chunk_first, 1);
    check("p1_last", chunk_last, 1);
    send(32'h61, 1'b0);
    send(32'h62, 1'b0);
    tvalid = 1'b1; tdata = 32'h63; tlast = 1'b1; strobe = 1'b1;
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0; strobe = 1'b0;
    check("cp_empty", fifo_empty, 0);
    check("cp_full", fifo_full, 0);
    check("cp_words", chunk_words, 3);
    check("cp_out0", fifo_out[0], 32'h61);
    pop_once();

    // Asynchronous reset mid-packet with a committed chunk held.
    send(32'h71, 1'b0);
    send(32'h72, 1'b1);
    for (int i = 0; i < 7; i++) send(W'(32'h700 + i), 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("ar_tready", tready, 0);
    check("ar_empty", fifo_empty, 1);
    check("ar_full", fifo_full, 0);
    check("ar_words", chunk_words, 0);
    check("ar_first", chunk_first, 0);
    check("ar_out0", fifo_out[0], 0);
    idle(3);
    rst_n = 1'b1;
    idle(1);
    pop_once();
    check("ar_strobe_empty", fifo_empty, 1);
    for (int i = 0; i < 16; i++) send(W'(32'h800 + i), i == 15);
    check("ar_words16", chunk_words, 16);
    check("ar_first16", chunk_first, 1);
    check("ar_last16", chunk_last, 1);
    check("ar_out3", fifo_out[3], 32'h803);
    pop_once();

    // Random traffic: slow consumer first, then a fast one.
    for (int c = 0; c < 1200; c++) begin
      tvalid = ($urandom_range(0, 3) != 0);
      tdata  = $urandom;
      tlast  = ($urandom_range(0, 7) == 0);
      strobe = (c < 600) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    tvalid = 1'b0; tlast = 1'b0; strobe = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
